// File: rtl/csr_read_arb.sv
// Two-requester round-robin arbiter for counter CSR reads.
// Each requester has a shadow of the high half so a lo/hi pair reads atomically.
module csr_read_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [11:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_addr,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_data,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_data,
  output logic        rsp1_err,
  output logic        cnt_rd,
  output logic        cnt_sel,
  input  logic [63:0] cnt_data
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_e;

  state_e state_q;

  logic last_q;
  logic id_q;
  logic cid_q;
  logic hi_q;

  logic [1:0]       sh_v_q;
  logic [1:0]       sh_tag_q;
  logic [1:0][31:0] sh_val_q;

  logic [1:0]       rsp_v_q;
  logic [1:0]       rsp_err_q;
  logic [1:0][31:0] rsp_data_q;

  logic        any;
  logic        gnt;
  logic [11:0] addr;
  logic        legal;
  logic        acc_cid;
  logic        acc_hi;
  logic        hit;
  logic        idle;

  always_comb begin
    any     = req0_valid | req1_valid;
    gnt     = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    addr    = gnt ? req1_addr : req0_addr;
    acc_cid = addr[1];
    acc_hi  = addr[7];
    legal   = (addr == 12'hC00) | (addr == 12'hC02) |
              (addr == 12'hC80) | (addr == 12'hC82);
    hit     = acc_hi & sh_v_q[gnt] & (sh_tag_q[gnt] == acc_cid);
    idle    = (state_q == IDLE) & ~rst;
  end

  assign req0_ready = idle & any & ~gnt;
  assign req1_ready = idle & any & gnt;

  assign cnt_rd  = (state_q == ISSUE);
  assign cnt_sel = cnt_rd & cid_q;

  assign rsp0_valid = rsp_v_q[0];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_valid = rsp_v_q[1];
  assign rsp1_data  = rsp_data_q[1];
  assign rsp1_err   = rsp_err_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      id_q       <= 1'b0;
      cid_q      <= 1'b0;
      hi_q       <= 1'b0;
      sh_v_q     <= '0;
      sh_tag_q   <= '0;
      sh_val_q   <= '0;
      rsp_v_q    <= '0;
      rsp_err_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any) begin
            last_q <= gnt;
            id_q   <= gnt;
            cid_q  <= acc_cid;
            hi_q   <= acc_hi;
            if (!legal) begin
              rsp_v_q[gnt]    <= 1'b1;
              rsp_err_q[gnt]  <= 1'b1;
              rsp_data_q[gnt] <= '0;
              state_q         <= RESP;
            end else if (hit) begin
              rsp_v_q[gnt]    <= 1'b1;
              rsp_data_q[gnt] <= sh_val_q[gnt];
              sh_v_q[gnt]     <= 1'b0;
              state_q         <= RESP;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rsp_v_q[id_q] <= 1'b1;
          // Low-half reads park the high half for an atomic follow-up read.
          if (hi_q) begin
            rsp_data_q[id_q] <= cnt_data[63:32];
          end else begin
            rsp_data_q[id_q] <= cnt_data[31:0];
            sh_val_q[id_q]   <= cnt_data[63:32];
            sh_tag_q[id_q]   <= cid_q;
            sh_v_q[id_q]     <= 1'b1;
          end
          state_q <= RESP;
        end
        RESP: begin
          rsp_v_q    <= '0;
          rsp_err_q  <= '0;
          rsp_data_q <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/csr_read_arb.md
CSR_READ_ARB -- requirements
Module: csr_read_arb

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high, as listed in REQ-002/REQ-003.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) read request.
REQ-005 reqN_addr  input  12  CSR address for requester N.
REQ-006 reqN_ready  output  1  request accepted this cycle.
REQ-007 rspN_valid  output  1  one-cycle response pulse to requester N.
REQ-008 rspN_data  output  32  read data, valid while rspN_valid=1.
REQ-009 rspN_err  output  1  illegal address flag, valid while rspN_valid=1.
REQ-010 cnt_rd  output  1  counter-port read strobe.
REQ-011 cnt_sel  output  1  counter select: 0=cycle, 1=instret.
REQ-012 cnt_data  input  64  full counter value, valid the cycle after cnt_rd=1.

Function
REQ-013 Address map SHALL be: 0xC00 cycle[31:0], 0xC02 instret[31:0], 0xC80 cycle[63:32], 0xC82 instret[63:32]; any other address is illegal.
REQ-014 FSM states SHALL be IDLE, ISSUE, CAPTURE, RESP.
REQ-015 reqN_ready SHALL be combinational; it is 1 only in IDLE for the granted requester, and 0 in every other state.
REQ-016 Arbitration SHALL be round-robin using a last_grant register.
- Only one requester valid: grant it.
- Both valid: grant the requester that is not last_grant.
- last_grant updates on accept.
REQ-017 An accepted request (cycle T) SHALL latch the requester id, the address and the counter id.
REQ-018 An accepted request that is a legal miss SHALL follow this sequence:
- T+1: ISSUE, with cnt_rd=1 and cnt_sel=counter id.
- T+2: CAPTURE, which latches cnt_data.
- T+3: RESP, with rsp_valid=1.
- T+4: return to IDLE.
REQ-019 cnt_rd SHALL be 1 only in ISSUE; cnt_sel SHALL hold the latched counter id in ISSUE and be 0 otherwise.
REQ-020 Each requester SHALL own a shadow register: 32-bit value, 1-bit counter tag, 1-bit valid.
REQ-021 A low-half read SHALL behave as follows:
- Return cnt_data[31:0].
- Write cnt_data[63:32] into that requester's shadow.
- Set the shadow tag to the counter id and set shadow valid to 1, overwriting any prior shadow.
REQ-022 A high-half read whose requester shadow is valid with a matching tag (a hit) SHALL behave as follows:
- Go IDLE->RESP at T+1 and return the shadow value.
- Clear shadow valid.
- Make no counter access.
REQ-023 A high-half read without a shadow hit SHALL take the full path of REQ-018, return cnt_data[63:32], and leave the shadow unchanged.
REQ-024 An illegal address SHALL behave as follows:
- Go IDLE->RESP at T+1 with rsp_err=1 and rsp_data=0.
- Make no counter access and leave the shadow unchanged.
REQ-025 In RESP, only the latched requester's rsp_valid SHALL be 1, for exactly one cycle.
REQ-026 rsp_data and rsp_err SHALL be registered and SHALL read 0 whenever rsp_valid=0.
REQ-027 Requesters SHALL hold reqN_valid and reqN_addr until ready, and SHALL accept every response; the block applies no response backpressure.
REQ-028 Requests arriving in ISSUE, CAPTURE or RESP SHALL wait; the earliest next accept is the cycle after RESP.
REQ-029 A requester's shadow SHALL be visible only to that requester; the other requester's reads never hit or modify it.

Reset
REQ-030 On rst=1 the block SHALL immediately and asynchronously set:
- FSM to IDLE.
- All outputs to 0.
- Both shadow valid bits to 0.
- last_grant to 1, so requester 0 wins the first contention.
REQ-031 A request in flight when reset asserts SHALL be dropped with no response; after release the block accepts new requests from IDLE on the first clock edge.

Verification
REQ-032 The bench SHALL cover these scenarios:
- Single low read: req0 0xC00 accepted at T, cnt_data=0x0000_0005_0000_0010 -> cnt_rd=1 and cnt_sel=0 at T+1; rsp0_valid=1 and rsp0_data=0x10 at T+3.
- Atomic high read: req0 0xC80 issued after the previous scenario -> rsp0_data=0x5 at accept+1, cnt_rd stays 0; a repeat 0xC80 goes through the counter path.
- Contention: req0 and req1 valid together after reset -> req0 is granted first; with both held, grants alternate 1,0,1.
- Shadow isolation: req0 reads 0xC02, then req1 reads 0xC82 -> the req1 read misses (cnt_rd=1, cnt_sel=1), and req0's shadow is still valid.
- Illegal address: req1 0x300 -> rsp1_valid=1, rsp1_err=1, rsp1_data=0 at accept+1, no cnt_rd.
- Reset in flight: rst asserted in CAPTURE -> no rsp pulse, all outputs 0, shadows invalid; the next request completes normally.
